data_mem_responder: RTL and testbench

//  Responder for the memory stage's data-memory requests (the pipeline is the initiator).
//  - Accepts one load/store per handshake.
//  - Stores data in an internal word array; the array is not reset.
//  - Returns a one-cycle response after a fixed latency.
//  - Drives busy so the pipeline can stall its M/W stages until the response arrives.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_word_array.sv | 30 +++
 rtl/data_mem_responder.sv | 117 +++++++++++
 tb/tb_data_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, bus widths and the address check.
// Imported by the responder top and its word array.
package dmem_pkg;

  localparam int STRB_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned or beyond the last byte of the array; widened so depth*4 cannot wrap.
  function automatic logic err_f(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] w_limit;
    w_limit = 34'(depth) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= w_limit);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word-organised storage with per-byte write enables, not reset.
// Latency: writes commit on the clock edge; the read port is combinational.
// No backpressure: a write is taken on every edge where any enable is set.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [AW-1:0]     i_idx,
  input  logic [STRB_W-1:0] i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  // Byte-granular store; lanes without an enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (i_we[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store per handshake, fixed-latency response pulse.
// Latency: rsp_valid is high in the LATENCY-th cycle after the accepting edge.
// Backpressure: req_ready only in IDLE; the response itself cannot be stalled.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Counter preload; only meaningful when a WAIT phase exists.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              r_write;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_err;
  logic [AW-1:0]     w_idx;
  logic [STRB_W-1:0] w_we;
  logic [DATA_W-1:0] w_rd_dat;

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_err     = err_f(req_addr, DEPTH_WORDS);
  assign w_idx     = req_addr[AW+1:2];
  // Stores commit at accept; an erroring store must not touch the array.
  assign w_we      = (w_accept && req_write && !w_err) ? req_wstrb : '0;

  dmem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_idx   (w_idx),
    .i_we    (w_we),
    .i_wdata (req_wdata),
    .o_rdata (w_rd_dat)
  );

  // State and wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE, counter paces WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture request attributes and the single array read at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_err   <= w_err;
      r_rdata <= w_rd_dat;
    end
  end

  // Response is driven purely from captured state; zeroed outside RESP.
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = (rsp_valid && !r_write && !r_err) ? r_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance driven from a vector
// table plus multi-cycle sequences, and a LATENCY=1 instance for the fast path.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_err, busy;

  logic        req1_valid = 1'b0, req1_ready, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0, rsp1_rdata;
  logic [3:0]  req1_wstrb = '0;
  logic        rsp1_valid, rsp1_err, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req1_valid), .req_ready(req1_ready), .req_write(req1_write),
    .req_addr(req1_addr), .req_wdata(req1_wdata), .req_wstrb(req1_wstrb),
    .rsp_valid(rsp1_valid), .rsp_rdata(rsp1_rdata), .rsp_err(rsp1_err), .busy(busy1)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; returns response fields and cycles to rsp_valid.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output int lat);
    bit found;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    chk("ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0; found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      chk("busy_active", 32'(busy), 32'd1);
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err; found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n_acc, n_rsp;
    int          acc_i[4];
    int          rsp_i[4];
    logic [31:0] rsp_d[4];
    logic [31:0] seq_a[3];
    int          pulses;

    tv[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    tv[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tv[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
    tv[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    tv[4]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'h0,         1'b1};
    tv[5]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    tv[6]  = '{1'b1, 32'h0000_0400, 32'hAAAA_AAAA, 4'hF, 32'h0,         1'b1};
    tv[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    tv[8]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
    tv[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    tv[10] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    tv[11] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    tv[12] = '{1'b0, 32'h0000_0402, 32'h0,         4'h0, 32'h0,         1'b1};
    tv[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};

    // Reset state
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 14; i++) begin
      do_req(tv[i].w, tv[i].a, tv[i].d, tv[i].s, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, tv[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(tv[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
    end

    // req_valid held high; req_* scrambled while not ready must be ignored
    seq_a[0] = 32'h10; seq_a[1] = 32'h3FC; seq_a[2] = 32'h0;
    n_acc = 0; n_rsp = 0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("hold_ready_c%0d", i), 32'(req_ready), 32'((i % 3) == 0));
      chk($sformatf("hold_busy_c%0d", i), 32'(busy), 32'((i % 3) != 0));
      if (rsp_valid && n_rsp < 4) begin
        rsp_i[n_rsp] = i; rsp_d[n_rsp] = rsp_rdata; n_rsp++;
      end
      if (req_ready && n_acc < 3) begin
        acc_i[n_acc] = i;
        req_valid = 1'b1; req_write = 1'b0; req_addr = seq_a[n_acc];
        req_wdata = '0; req_wstrb = 4'h0;
        n_acc++;
      end else begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0;
        req_wdata = 32'h0; req_wstrb = 4'hF;
      end
    end
    req_valid = 1'b0; req_write = 1'b0;
    chk("hold_n_acc", 32'(n_acc), 32'd3);
    chk("hold_n_rsp", 32'(n_rsp), 32'd3);
    if (n_acc == 3) begin
      chk("hold_spacing1", 32'(acc_i[1] - acc_i[0]), 32'd3);
      chk("hold_spacing2", 32'(acc_i[2] - acc_i[1]), 32'd3);
    end
    if (n_rsp == 3) begin
      chk("hold_rsp0", rsp_d[0], 32'hDE22_BE44);
      chk("hold_rsp1", rsp_d[1], 32'h1234_5678);
      chk("hold_rsp2", rsp_d[2], 32'hCAFE_F00D);
      chk("hold_rsp0_cyc", 32'(rsp_i[0]), 32'd2);
    end
    do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("hold_word0_intact", rd, 32'hCAFE_F00D);

    // Reset during WAIT of a store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h55AA_55AA; req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    chk("midrst_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("midrst_no_rsp", 32'(pulses), 32'd0);
    chk("midrst_idle", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_store_kept", rd, 32'h55AA_55AA);
    chk("midrst_load_err", 32'(er), 32'd0);

    // LATENCY=1 instance: store then two loads with valid held high
    n_acc = 0; n_rsp = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("l1_ready_c%0d", i), 32'(req1_ready), 32'((i % 2) == 0));
      if (rsp1_valid && n_rsp < 4) begin
        rsp_i[n_rsp] = i; rsp_d[n_rsp] = rsp1_rdata; n_rsp++;
      end
      if (req1_ready && n_acc < 3) begin
        acc_i[n_acc] = i;
        req1_valid = 1'b1; req1_write = (n_acc == 0); req1_addr = 32'h10;
        req1_wdata = 32'hA5A5_5A5A; req1_wstrb = 4'hF;
        n_acc++;
      end
    end
    req1_valid = 1'b0;
    chk("l1_n_acc", 32'(n_acc), 32'd3);
    chk("l1_n_rsp", 32'(n_rsp), 32'd3);
    if (n_acc == 3 && n_rsp == 3) begin
      chk("l1_lat0", 32'(rsp_i[0] - acc_i[0]), 32'd1);
      chk("l1_lat1", 32'(rsp_i[1] - acc_i[1]), 32'd1);
      chk("l1_spacing", 32'(acc_i[2] - acc_i[1]), 32'd2);
      chk("l1_store_rdata", rsp_d[0], 32'h0);
      chk("l1_load1", rsp_d[1], 32'hA5A5_5A5A);
      chk("l1_load2", rsp_d[2], 32'hA5A5_5A5A);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
